// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions used by the line responder and the cache:
// word width, FSM/op encodings and the line container type.
package mem_if_pkg;

  localparam int WORD_W            = 32;
  localparam int DEF_LINE_ADDR_LEN = 3;
  localparam int DEF_ADDR_LEN      = 10;
  localparam int LINE_WORDS        = 2 ** DEF_LINE_ADDR_LEN;
  localparam int LINE_W            = WORD_W * LINE_WORDS;
  localparam int CNT_W             = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/mem_line_array.sv
// Line-wide synchronous storage. Lines never written since time zero read back
// the init pattern {line, word} via a per-line written flag, so reset never touches contents.
module mem_line_array
  import mem_if_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int ADDR_LEN      = DEF_ADDR_LEN
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   we_i,
  input  logic                                   re_i,
  input  logic [ADDR_LEN-1:0]                    addr_i,
  input  logic [WORD_W*(2**LINE_ADDR_LEN)-1:0]   wdata_i,
  output logic [WORD_W*(2**LINE_ADDR_LEN)-1:0]   rdata_o
);

  localparam int WORDS = 2 ** LINE_ADDR_LEN;
  localparam int LW    = WORD_W * WORDS;
  localparam int DEPTH = 2 ** ADDR_LEN;

  logic [LW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] written_q = {DEPTH{1'b0}};
  logic [LW-1:0]    rdata_q;

  function automatic logic [LW-1:0] init_line(input logic [ADDR_LEN-1:0] a);
    logic [LW-1:0]            l;
    logic [LINE_ADDR_LEN-1:0] kw;
    l = {LW{1'b0}};
    for (int k = 0; k < WORDS; k++) begin
      kw = LINE_ADDR_LEN'(k);
      l[k*WORD_W +: WORD_W] = WORD_W'({a, kw});
    end
    return l;
  endfunction

  // storage write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i]     <= wdata_i;
      written_q[addr_i] <= 1'b1;
    end
  end

  // registered read port
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= {LW{1'b0}};
    end else if (re_i) begin
      rdata_q <= written_q[addr_i] ? mem_q[addr_i] : init_line(addr_i);
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Line-granular memory model: accepts a read/write, waits LATENCY cycles, commits, pulses gnt.
// Optional access counters are built when MEM_STATS_EN is defined.
module line_mem_responder
  import mem_if_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int ADDR_LEN      = DEF_ADDR_LEN,
  parameter int LATENCY       = 50
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDR_LEN-1:0]                  addr,
  input  logic                                 rd_req,
  input  logic                                 wr_req,
  input  logic [WORD_W*(2**LINE_ADDR_LEN)-1:0] wr_line,
  output logic [WORD_W*(2**LINE_ADDR_LEN)-1:0] rd_line,
  output logic                                 gnt
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]                          rd_count,
  output logic [31:0]                          wr_count
`endif
);

  localparam int LW = WORD_W * (2 ** LINE_ADDR_LEN);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [LW-1:0]       wline_q, wline_d;
  logic                gnt_q, gnt_d;
  logic                mem_we_s, mem_re_s, op_req_s;

  assign op_req_s = (op_q == OP_WR) ? wr_req : rd_req;

  // next-state and commit strobes
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wline_d  = wline_q;
    mem_we_s = 1'b0;
    mem_re_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          op_d    = OP_WR;
          addr_d  = addr;
          wline_d = wr_line;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end else if (rd_req) begin
          op_d    = OP_RD;
          addr_d  = addr;
          wline_d = wr_line;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // requester withdrawal wins over completion on the same edge
        if (!op_req_s) begin
          state_d = IDLE;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d  = DONE;
          mem_we_s = (op_q == OP_WR);
          mem_re_s = (op_q == OP_RD);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == DONE);
  end

  // FSM and request latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      cnt_q   <= {CNT_W{1'b0}};
      addr_q  <= {ADDR_LEN{1'b0}};
      wline_q <= {LW{1'b0}};
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      gnt_q   <= gnt_d;
    end
  end

  mem_line_array #(
    .LINE_ADDR_LEN(LINE_ADDR_LEN),
    .ADDR_LEN     (ADDR_LEN)
  ) u_array (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (mem_we_s),
    .re_i   (mem_re_s),
    .addr_i (addr_q),
    .wdata_i(wline_q),
    .rdata_o(rd_line)
  );

  assign gnt = gnt_q;

`ifdef MEM_STATS_EN
  logic [31:0] rd_count_q, wr_count_q;

  // completed-access counters, bumped on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      if (mem_re_s) rd_count_q <= rd_count_q + 32'd1;
      if (mem_we_s) wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder with LATENCY=4; covers stats when MEM_STATS_EN is defined.
module tb_line_mem_responder;

  localparam int LAT = 4;
  localparam int LW  = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    addr;
  logic          rd_req, wr_req;
  logic [LW-1:0] wr_line, rd_line;
  logic          gnt;
`ifdef MEM_STATS_EN
  logic [31:0]   rd_count, wr_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  line_mem_responder #(.LINE_ADDR_LEN(3), .ADDR_LEN(10), .LATENCY(LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .rd_req (rd_req),
    .wr_req (wr_req),
    .wr_line(wr_line),
    .rd_line(rd_line),
`ifdef MEM_STATS_EN
    .rd_count(rd_count),
    .wr_count(wr_count),
`endif
    .gnt    (gnt)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] pat(input int line);
    logic [LW-1:0] p;
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = 32'(line * 8 + k);
    return p;
  endfunction

  function automatic logic [LW-1:0] seq(input int base);
    logic [LW-1:0] p;
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = 32'(base + k);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one full transaction; lat = edge index of gnt after acceptance edge (0), -1 on timeout
  task automatic do_req(input logic is_wr, input logic [9:0] a, input logic [LW-1:0] line,
                        output int lat);
    lat     = -1;
    addr    = a;
    wr_line = line;
    if (is_wr) wr_req = 1'b1; else rd_req = 1'b1;
    for (int e = 0; e < 40; e++) begin
      step();
      if (gnt === 1'b1) begin
        lat = e;
        break;
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = 10'd0; wr_line = '0;
    step(); step();
    n_cmp++; if (gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    n_cmp++; if (rd_line !== '0) begin n_err++; $display("FAIL reset_rd_line: got %h want 0", rd_line); end
`ifdef MEM_STATS_EN
    n_cmp++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
      n_err++; $display("FAIL reset_stats: got %0d/%0d want 0/0", rd_count, wr_count); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    int extra;
    addr = 10'h005; rd_req = 1'b1;
    for (int e = 0; e <= LAT; e++) begin
      step();
      n_cmp++; if (gnt !== (e == LAT)) begin
        n_err++; $display("FAIL read_gnt_timing e%0d: got %b want %b", e, gnt, (e == LAT)); end
    end
    n_cmp++; if (rd_line !== pat(5)) begin
      n_err++; $display("FAIL read_data: got %h want %h", rd_line, pat(5)); end
    step();
    n_cmp++; if (gnt !== 1'b0) begin n_err++; $display("FAIL read_gnt_fall: got %b want 0", gnt); end
    rd_req = 1'b0;
    extra = 0;
    for (int e = 0; e < 12; e++) begin step(); if (gnt === 1'b1) extra++; end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL read_no_regrant: got %0d grants want 0", extra); end
  endtask

  task automatic test_write_read();
    int lat;
    do_req(1'b1, 10'h003, seq(32'hA0), lat);
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL wr_latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (rd_line !== pat(5)) begin
      n_err++; $display("FAIL wr_keeps_rd_line: got %h want %h", rd_line, pat(5)); end
    do_req(1'b0, 10'h003, '0, lat);
    n_cmp++; if (rd_line !== seq(32'hA0)) begin
      n_err++; $display("FAIL wr_then_rd: got %h want %h", rd_line, seq(32'hA0)); end
  endtask

  task automatic test_back_to_back();
    int g1 = -1, g2 = -1;
    addr = 10'h010; wr_line = seq(32'h1234); wr_req = 1'b1;
    for (int e = 0; e < 30; e++) begin
      step();
      if (gnt === 1'b1) begin
        if (g1 < 0) begin
          g1 = e; wr_req = 1'b0; rd_req = 1'b1; addr = 10'h011;
        end else if (g2 < 0) begin
          g2 = e; rd_req = 1'b0;
        end
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    n_cmp++; if (g1 !== LAT) begin n_err++; $display("FAIL b2b_first_gnt: got %0d want %0d", g1, LAT); end
    n_cmp++; if (g2 !== 2 * LAT + 2) begin
      n_err++; $display("FAIL b2b_second_gnt: got %0d want %0d", g2, 2 * LAT + 2); end
    n_cmp++; if (rd_line !== pat(32'h011)) begin
      n_err++; $display("FAIL b2b_refill_data: got %h want %h", rd_line, pat(32'h011)); end
  endtask

  task automatic test_abort();
    int ng, lat;
    addr = 10'h007; rd_req = 1'b1;
    step(); step(); step();
    rd_req = 1'b0;
    ng = 0;
    for (int e = 0; e < 10; e++) begin step(); if (gnt === 1'b1) ng++; end
    n_cmp++; if (ng !== 0) begin n_err++; $display("FAIL abort_rd_gnt: got %0d grants want 0", ng); end
    n_cmp++; if (rd_line !== pat(32'h011)) begin
      n_err++; $display("FAIL abort_rd_line: got %h want %h", rd_line, pat(32'h011)); end
    addr = 10'h009; wr_line = seq(32'hDEAD0); wr_req = 1'b1;
    step(); step(); step();
    wr_req = 1'b0;
    ng = 0;
    for (int e = 0; e < 10; e++) begin step(); if (gnt === 1'b1) ng++; end
    n_cmp++; if (ng !== 0) begin n_err++; $display("FAIL abort_wr_gnt: got %0d grants want 0", ng); end
    do_req(1'b0, 10'h009, '0, lat);
    n_cmp++; if (rd_line !== pat(9)) begin
      n_err++; $display("FAIL abort_wr_no_commit: got %h want %h", rd_line, pat(9)); end
  endtask

  task automatic test_priority();
    int g, lat;
    addr = 10'h020; wr_line = seq(32'h55); wr_req = 1'b1; rd_req = 1'b1;
    g = -1;
    for (int e = 0; e < 20; e++) begin
      step();
      if (gnt === 1'b1 && g < 0) begin g = e; wr_req = 1'b0; rd_req = 1'b0; end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    n_cmp++; if (g !== LAT) begin n_err++; $display("FAIL prio_gnt: got %0d want %0d", g, LAT); end
    n_cmp++; if (rd_line !== pat(9)) begin
      n_err++; $display("FAIL prio_rd_line_kept: got %h want %h", rd_line, pat(9)); end
    do_req(1'b0, 10'h020, '0, lat);
    n_cmp++; if (rd_line !== seq(32'h55)) begin
      n_err++; $display("FAIL prio_write_won: got %h want %h", rd_line, seq(32'h55)); end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    addr = 10'h030; wr_line = seq(32'h77); wr_req = 1'b1;
    step(); step(); step();
    rst = 1'b1;
    #1;
    n_cmp++; if (gnt !== 1'b0) begin n_err++; $display("FAIL rst_mid_gnt: got %b want 0", gnt); end
    n_cmp++; if (rd_line !== '0) begin n_err++; $display("FAIL rst_mid_rd_line: got %h want 0", rd_line); end
    wr_req = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    do_req(1'b0, 10'h030, '0, lat);
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL rst_recover_lat: got %0d want %0d", lat, LAT); end
    n_cmp++; if (rd_line !== pat(32'h030)) begin
      n_err++; $display("FAIL rst_no_commit: got %h want %h", rd_line, pat(32'h030)); end
  endtask

`ifdef MEM_STATS_EN
  task automatic test_stats();
    int lat;
    rst = 1'b1; step(); rst = 1'b0; step();
    do_req(1'b0, 10'h001, '0, lat);
    do_req(1'b1, 10'h002, seq(32'h10), lat);
    do_req(1'b0, 10'h002, '0, lat);
    do_req(1'b1, 10'h004, seq(32'h20), lat);
    addr = 10'h006; rd_req = 1'b1;
    step(); step();
    rd_req = 1'b0;
    for (int e = 0; e < 8; e++) step();
    do_req(1'b0, 10'h004, '0, lat);
    n_cmp++; if (rd_count !== 32'd3) begin n_err++; $display("FAIL stats_rd: got %0d want 3", rd_count); end
    n_cmp++; if (wr_count !== 32'd2) begin n_err++; $display("FAIL stats_wr: got %0d want 2", wr_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_back_to_back();
    test_abort();
    test_priority();
    test_reset_mid_busy();
`ifdef MEM_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
